// File: rtl/mod_n_pkg.sv
// Shared types, defaults and the next-value helper for mod-N counters and checkers.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package mod_n_pkg;

  // Default modulus and bus width, shared with the mod-N counter.
  localparam int MOD_N_N     = 10;
  localparam int MOD_N_WIDTH = 4;

  // Checker FSM states; HALT is only reachable in the sticky build.
  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    LOCKED = 2'd1,
    HALT   = 2'd2
  } state_t;

  // Successor of x in the sequence 0..n-1,0,...
  function automatic int unsigned mod_n_next(input int unsigned x, input int unsigned n);
    return (x == n - 32'd1) ? 32'd0 : x + 32'd1;
  endfunction

endpackage

// File: rtl/mod_n_seq_checker_if.sv
// Observation bus between a mod-N counter stream and its sequence checker.
// Latency: none (signal bundle only).
// Backpressure: none; the checker samples on every enabled edge.
// Optional macro MOD_N_SEQ_CHECKER_STICKY_EN adds the err_sticky signal.
interface mod_n_seq_checker_if
  import mod_n_pkg::*;
#(
  parameter int WIDTH = MOD_N_WIDTH,
  parameter int ERR_W = 8
);

  logic             en;
  logic             clr;
  logic [WIDTH-1:0] cnt_in;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [ERR_W-1:0] err_cnt;
`ifdef MOD_N_SEQ_CHECKER_STICKY_EN
  logic             err_sticky;

  modport master (output en, clr, cnt_in, input locked, err, wrap, err_cnt, err_sticky);
  modport slave  (input en, clr, cnt_in, output locked, err, wrap, err_cnt, err_sticky);
`else
  modport master (output en, clr, cnt_in, input locked, err, wrap, err_cnt);
  modport slave  (input en, clr, cnt_in, output locked, err, wrap, err_cnt);
`endif

endinterface

// File: rtl/mod_n_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Latency: count updates on the edge where inc or clr is sampled.
// Backpressure: none; clr has priority over inc.
module mod_n_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, stop at the maximum, clear on request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod_n_seq_checker.sv
// Monitors a mod-N count stream, locks after LOCK_CNT in-sequence samples, flags breaks.
// Latency: a sample taken on edge k is reflected in all (registered) outputs right after edge k.
// Backpressure: none; en=0 freezes state, clr overrides en. Macro: MOD_N_SEQ_CHECKER_STICKY_EN.
module mod_n_seq_checker
  import mod_n_pkg::*;
#(
  parameter int N        = MOD_N_N,
  parameter int WIDTH    = MOD_N_WIDTH,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input logic                clk,
  input logic                rstn,
  mod_n_seq_checker_if.slave bus
);

  localparam int               MW     = $clog2(LOCK_CNT + 1);
  // Modulus held one bit wider than the bus so N == 2**WIDTH compares correctly.
  localparam logic [WIDTH:0]   N_W    = (WIDTH + 1)'(N);
  localparam logic [MW-1:0]    LOCK_W = MW'(LOCK_CNT);

  state_t           state;
  logic [MW-1:0]    match_cnt;
  logic [WIDTH-1:0] expected;
  logic             locked_q;
  logic             err_q;
  logic             wrap_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic             legal;
  logic             hit;
  logic             err_now;
  logic [WIDTH-1:0] nxt;
  logic [MW-1:0]    match_inc;

  // Decode the current sample: legality, match against expectation, error on this edge.
  always_comb begin
    legal     = ({1'b0, bus.cnt_in} < N_W);
    hit       = legal && (bus.cnt_in == expected);
    nxt       = WIDTH'(mod_n_next(32'(bus.cnt_in), N));
    match_inc = (hit && (match_cnt != '0)) ? match_cnt + 1'b1 : MW'(1);
    err_now   = 1'b0;
    if (bus.en && !bus.clr) begin
      case (state)
        SYNC:    err_now = !legal;
        LOCKED:  err_now = !hit;
        default: err_now = 1'b0;
      endcase
    end
  end

  // Sequence FSM with registered locked/err/wrap outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= SYNC;
      match_cnt <= '0;
      expected  <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      err_q  <= err_now;
      wrap_q <= 1'b0;
      if (bus.clr) begin
        state     <= SYNC;
        match_cnt <= '0;
        expected  <= '0;
        locked_q  <= 1'b0;
      end else if (bus.en) begin
        case (state)
          SYNC: begin
            if (!legal) begin
              // Illegal value breaks any run in progress; expected is irrelevant until reseeded.
              match_cnt <= '0;
            end else begin
              match_cnt <= match_inc;
              expected  <= nxt;
              if (match_inc == LOCK_W) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (hit) begin
              expected <= nxt;
              wrap_q   <= (bus.cnt_in == '0);
            end else begin
              locked_q <= 1'b0;
`ifdef MOD_N_SEQ_CHECKER_STICKY_EN
              state    <= HALT;
`else
              state    <= SYNC;
`endif
              // A legal offending value becomes the seed of the next run.
              if (legal) begin
                match_cnt <= MW'(1);
                expected  <= nxt;
              end else begin
                match_cnt <= '0;
              end
            end
          end
          default: begin
            // HALT: frozen until clr or reset.
          end
        endcase
      end
    end
  end

  mod_n_sat_cnt #(.W(ERR_W)) u_err_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (bus.clr),
    .inc  (err_now),
    .cnt  (err_cnt_q)
  );

`ifdef MOD_N_SEQ_CHECKER_STICKY_EN
  logic sticky_q;

  // Latch any error until clr or reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_q <= 1'b0;
    end else if (bus.clr) begin
      sticky_q <= 1'b0;
    end else if (err_now) begin
      sticky_q <= 1'b1;
    end
  end

  assign bus.err_sticky = sticky_q;
`endif

  assign bus.locked  = locked_q;
  assign bus.err     = err_q;
  assign bus.wrap    = wrap_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mod_n_seq_checker.sv
// Bench for mod_n_seq_checker: vector table, directed corner sequences, random vs. model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_mod_n_seq_checker;

  localparam int N        = 10;
  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 8;
  localparam int ECMAX    = (1 << ERR_W) - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  mod_n_seq_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

  mod_n_seq_checker #(
    .N        (N),
    .WIDTH    (WIDTH),
    .LOCK_CNT (LOCK_CNT),
    .ERR_W    (ERR_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] cnt;
    logic       l;
    logic       e;
    logic       w;
    int         c;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic en, input logic clr, input logic [3:0] cnt,
                     input logic l, input logic e, input logic w, input int c);
    vec_t v;
    v.en = en; v.clr = clr; v.cnt = cnt; v.l = l; v.e = e; v.w = w; v.c = c;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int l, input int e, input int w, input int c);
    chk({tag, ".locked"}, 32'(bus.locked), l);
    chk({tag, ".err"}, 32'(bus.err), e);
    chk({tag, ".wrap"}, 32'(bus.wrap), w);
    chk({tag, ".err_cnt"}, 32'(bus.err_cnt), c);
  endtask

  task automatic step(input logic en, input logic clr, input logic [WIDTH-1:0] cnt);
    bus.en     = en;
    bus.clr    = clr;
    bus.cnt_in = cnt;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a history of the current in-sequence run plus lock/halt flags.
  int run_q[$];
  bit m_locked, m_halt, m_sticky, m_err, m_wrap;
  int m_ecnt;

  task automatic model_reset();
    run_q.delete();
    m_locked = 0; m_halt = 0; m_sticky = 0; m_err = 0; m_wrap = 0; m_ecnt = 0;
  endtask

  task automatic model_step(input bit en, input bit clr, input int cnt);
    bit legal;
    m_err  = 0;
    m_wrap = 0;
    legal  = (cnt < N);
    if (clr) begin
      run_q.delete();
      m_locked = 0; m_halt = 0; m_sticky = 0; m_ecnt = 0;
    end else if (en && !m_halt) begin
      if (!m_locked) begin
        if (!legal) begin
          run_q.delete();
          m_err = 1;
        end else if (run_q.size() > 0 && cnt == (run_q[$] + 1) % N) begin
          run_q.push_back(cnt);
        end else begin
          run_q.delete();
          run_q.push_back(cnt);
        end
        if (run_q.size() >= LOCK_CNT) m_locked = 1;
      end else begin
        if (legal && cnt == (run_q[$] + 1) % N) begin
          m_wrap = (cnt == 0);
          run_q.push_back(cnt);
          if (run_q.size() > LOCK_CNT) void'(run_q.pop_front());
        end else begin
          m_err    = 1;
          m_locked = 0;
          run_q.delete();
          if (legal) run_q.push_back(cnt);
`ifdef MOD_N_SEQ_CHECKER_STICKY_EN
          m_halt = 1;
`endif
        end
      end
      if (m_err) begin
        m_ecnt   = (m_ecnt + 1 > ECMAX) ? ECMAX : m_ecnt + 1;
        m_sticky = 1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int src;
    bus.en = 0; bus.clr = 0; bus.cnt_in = '0;
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1;

`ifndef MOD_N_SEQ_CHECKER_STICKY_EN
    // Clean stream 0..9,0: lock after sampling 2, single wrap on the final 0.
    for (int i = 0; i < 10; i++) add(1, 0, 4'(i), (i >= 2), 0, 0, 0);
    add(1, 0, 4'd0, 1, 0, 1, 0);
    for (int i = 1; i <= 5; i++) add(1, 0, 4'(i), 1, 0, 0, 0);
    // Skip 5 -> 7: error drops lock, 7,8,9 reseed and relock at 9.
    add(1, 0, 4'd7, 0, 1, 0, 1);
    add(1, 0, 4'd8, 0, 0, 0, 1);
    add(1, 0, 4'd9, 1, 0, 0, 1);
    add(1, 0, 4'd0, 1, 0, 1, 1);
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].en, tv[i].clr, tv[i].cnt);
      chk_out($sformatf("tv%0d", i), tv[i].l, tv[i].e, tv[i].w, tv[i].c);
    end

    // Illegal value while locked, then relock on 0,1,2.
    step(1, 0, 4'd12); chk_out("illegal", 0, 1, 0, 2);
    step(1, 0, 4'd0);  chk_out("relock0", 0, 0, 0, 2);
    step(1, 0, 4'd1);  chk_out("relock1", 0, 0, 0, 2);
    step(1, 0, 4'd2);  chk_out("relock2", 1, 0, 0, 2);
    for (int v = 3; v <= 5; v++) begin
      step(1, 0, 4'(v)); chk_out("run", 1, 0, 0, 2);
    end
    // en=0 with random values: nothing moves.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 4'($urandom_range(0, 15))); chk_out("hold", 1, 0, 0, 2);
    end
    for (int v = 6; v <= 11; v++) begin
      step(1, 0, 4'(v % N)); chk_out("resume", 1, 0, (v % N == 0), 2);
    end

    // Saturate the error counter.
    for (int i = 0; i < 260; i++) begin
      step(1, 0, 4'($urandom_range(10, 15)));
      chk("sat.err", 32'(bus.err), 1);
    end
    chk("sat.err_cnt", 32'(bus.err_cnt), ECMAX);
    step(1, 0, 4'd14); chk_out("sat_hold", 0, 1, 0, ECMAX);
    step(1, 1, 4'd15); chk_out("clr", 0, 0, 0, 0);

    // clr beats a matching sample while locked.
    step(1, 0, 4'd0); step(1, 0, 4'd1); step(1, 0, 4'd2);
    chk("clr_pre.locked", 32'(bus.locked), 1);
    step(1, 1, 4'd3); chk_out("clr_wins", 0, 0, 0, 0);

    // Asynchronous reset while locked with a nonzero error count.
    step(1, 0, 4'd13); chk_out("pre_rst_err", 0, 1, 0, 1);
    step(1, 0, 4'd0); step(1, 0, 4'd1); step(1, 0, 4'd2);
    step(1, 0, 4'd3); chk_out("pre_rst", 1, 0, 0, 1);
    #3 rstn = 0;
    #1 chk_out("rst_async", 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1;
    step(1, 0, 4'd4); chk_out("post_rst4", 0, 0, 0, 0);
    step(1, 0, 4'd5); chk_out("post_rst5", 0, 0, 0, 0);
    step(1, 0, 4'd6); chk_out("post_rst6", 1, 0, 0, 0);
`else
    // Sticky build: a skip while locked halts the checker until clr.
    step(1, 0, 4'd0); step(1, 0, 4'd1); step(1, 0, 4'd2);
    chk_out("st_lock", 1, 0, 0, 0);
    chk("st_lock.sticky", 32'(bus.err_sticky), 0);
    step(1, 0, 4'd3);
    step(1, 0, 4'd5); chk_out("st_skip", 0, 1, 0, 1);
    chk("st_skip.sticky", 32'(bus.err_sticky), 1);
    for (int v = 6; v <= 10; v++) begin
      step(1, 0, 4'(v % N)); chk_out("st_halt", 0, 0, 0, 1);
    end
    step(1, 0, 4'd14); chk_out("st_halt_ill", 0, 0, 0, 1);
    step(1, 1, 4'd1); chk_out("st_clr", 0, 0, 0, 0);
    chk("st_clr.sticky", 32'(bus.err_sticky), 0);
    step(1, 0, 4'd2); step(1, 0, 4'd3);
    step(1, 0, 4'd4); chk_out("st_relock", 1, 0, 0, 0);
`endif

    // Random phase against the reference model.
    rstn = 0;
    model_reset();
    @(negedge clk);
    rstn = 1;
    src = 0;
    for (int i = 0; i < 3000; i++) begin
      bit en, clr;
      int r, cnt;
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 79) == 0);
      r   = $urandom_range(0, 99);
      if (r < 88)      cnt = src;
      else if (r < 94) cnt = $urandom_range(0, N - 1);
      else             cnt = $urandom_range(0, 15);
      if (en && cnt == src) src = (src + 1) % N;
      model_step(en, clr, cnt);
      step(en, clr, 4'(cnt));
      chk_out($sformatf("rnd%0d", i), m_locked, m_err, m_wrap, m_ecnt);
`ifdef MOD_N_SEQ_CHECKER_STICKY_EN
      chk($sformatf("rnd%0d.sticky", i), 32'(bus.err_sticky), m_sticky);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
